// File: rtl/controlador_motor_multi.sv
// Multi-channel H-bridge controller: soft-start ramps, dead time on reversal,
// brake, and a global pause push-button that parks every channel in coast.
module controlador_motor_multi #(
    parameter int N_CH         = 2,
    parameter int PWM_BITS     = 8,
    parameter int RAMP_DIV     = 1000,
    parameter int DEAD_CYCLES  = 50000,
    parameter int PAUSE_CYCLES = 100000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*N_CH-1:0]        sel,
    input  logic [N_CH*PWM_BITS-1:0] pwm_duty,
    input  logic                     boton_pausa,
    output logic [N_CH-1:0]          AIN1,
    output logic [N_CH-1:0]          AIN2,
    output logic [N_CH-1:0]          PWMA,
    output logic                     STBY,
    output logic                     pausa,
    output logic [N_CH-1:0]          ocupado
);
    localparam int DIV_W  = $clog2(RAMP_DIV + 1);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int PAU_W  = $clog2(PAUSE_CYCLES + 1);
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(RAMP_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ONE   = DIV_W'(1);
    localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [DEAD_W-1:0]   DEAD_ONE  = DEAD_W'(1);
    localparam logic [PAU_W-1:0]    PAU_LOAD  = PAU_W'(PAUSE_CYCLES - 1);
    localparam logic [PAU_W-1:0]    PAU_ONE   = PAU_W'(1);
    localparam logic [PWM_BITS-1:0] D_ONE     = PWM_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_RAMP_DN, S_DEAD, S_BRAKE
    } state_t;

    logic [2*N_CH-1:0]        r_sel;
    logic [N_CH*PWM_BITS-1:0] r_tgt;
    logic [PWM_BITS-1:0]      r_cnt;
    logic [2:0]               r_sync;
    logic                     r_pausa;
    logic                     r_stby;
    logic [PAU_W-1:0]         r_timer;
    logic [N_CH-1:0]          r_ain1, r_ain2, r_pwma, r_ocup;
    logic [N_CH-1:0]          r_dir;

    state_t                   r_st   [N_CH];
    logic [PWM_BITS-1:0]      r_duty [N_CH];
    logic [DIV_W-1:0]         r_div  [N_CH];
    logic [DEAD_W-1:0]        r_dead [N_CH];

    logic                     w_press, w_pausa_nxt, w_hold;
    logic [PAU_W-1:0]         w_timer_nxt;
    state_t                   w_st_nxt   [N_CH];
    logic [PWM_BITS-1:0]      w_duty_nxt [N_CH];
    logic [DIV_W-1:0]         w_div_nxt  [N_CH];
    logic [DEAD_W-1:0]        w_dead_nxt [N_CH];
    logic [N_CH-1:0]          w_dir_nxt;
    logic [N_CH-1:0]          w_ain1, w_ain2, w_pwma, w_ocup;
    logic [1:0]               w_s;
    logic [PWM_BITS-1:0]      w_tg;
    logic                     w_step, w_fwd, w_same;

    assign w_press = r_sync[1] & ~r_sync[2];

    // A press while already paused is ignored; the timer never retriggers.
    always_comb begin
        w_pausa_nxt = r_pausa;
        w_timer_nxt = r_timer;
        if (r_pausa) begin
            if (r_timer == '0) w_pausa_nxt = 1'b0;
            else               w_timer_nxt = r_timer - PAU_ONE;
        end else if (w_press) begin
            w_pausa_nxt = 1'b1;
            w_timer_nxt = PAU_LOAD;
        end
    end

    // Channels stay parked through the cycle in which the pause expires.
    assign w_hold = r_pausa | w_pausa_nxt;

    always_comb begin
        w_s       = '0;
        w_tg      = '0;
        w_step    = 1'b0;
        w_fwd     = 1'b0;
        w_same    = 1'b0;
        w_dir_nxt = r_dir;
        for (int i = 0; i < N_CH; i++) begin
            w_s           = r_sel[2*i +: 2];
            w_tg          = r_tgt[PWM_BITS*i +: PWM_BITS];
            w_step        = (r_div[i] == DIV_LAST);
            w_fwd         = w_s[0] ^ w_s[1];
            w_same        = w_fwd && (w_s[1] == r_dir[i]);
            w_st_nxt[i]   = r_st[i];
            w_duty_nxt[i] = r_duty[i];
            w_div_nxt[i]  = '0;
            w_dead_nxt[i] = '0;
            if (w_hold) begin
                w_st_nxt[i]   = S_IDLE;
                w_duty_nxt[i] = '0;
            end else begin
                unique case (r_st[i])
                    S_IDLE: begin
                        w_duty_nxt[i] = '0;
                        if (w_fwd) begin
                            w_st_nxt[i]  = S_RUN;
                            w_dir_nxt[i] = w_s[1];
                        end else if (w_s == 2'b11) begin
                            w_st_nxt[i] = S_BRAKE;
                        end
                    end
                    S_RUN: begin
                        if (w_s == 2'b11) begin
                            w_st_nxt[i]   = S_BRAKE;
                            w_duty_nxt[i] = '0;
                        end else if (!w_same) begin
                            w_st_nxt[i] = S_RAMP_DN;
                        end else begin
                            w_div_nxt[i] = w_step ? '0 : r_div[i] + DIV_ONE;
                            if (w_step && r_duty[i] < w_tg)
                                w_duty_nxt[i] = r_duty[i] + D_ONE;
                            else if (w_step && r_duty[i] > w_tg)
                                w_duty_nxt[i] = r_duty[i] - D_ONE;
                        end
                    end
                    S_RAMP_DN: begin
                        if (w_same) begin
                            w_st_nxt[i] = S_RUN;
                        end else begin
                            w_div_nxt[i] = w_step ? '0 : r_div[i] + DIV_ONE;
                            if (w_step && r_duty[i] != '0)
                                w_duty_nxt[i] = r_duty[i] - D_ONE;
                            if (w_duty_nxt[i] == '0)
                                w_st_nxt[i] = w_fwd ? S_DEAD : S_IDLE;
                        end
                    end
                    S_DEAD: begin
                        w_duty_nxt[i] = '0;
                        if (r_dead[i] == DEAD_LAST) begin
                            if (w_fwd) begin
                                w_st_nxt[i]  = S_RUN;
                                w_dir_nxt[i] = w_s[1];
                            end else if (w_s == 2'b11) begin
                                w_st_nxt[i] = S_BRAKE;
                            end else begin
                                w_st_nxt[i] = S_IDLE;
                            end
                        end else begin
                            w_dead_nxt[i] = r_dead[i] + DEAD_ONE;
                        end
                    end
                    S_BRAKE: begin
                        w_duty_nxt[i] = '0;
                        if (w_s == 2'b00)  w_st_nxt[i] = S_IDLE;
                        else if (w_fwd)    w_st_nxt[i] = S_DEAD;
                    end
                    default: begin
                        w_st_nxt[i]   = S_IDLE;
                        w_duty_nxt[i] = '0;
                    end
                endcase
            end
            if (w_st_nxt[i] != r_st[i]) w_div_nxt[i] = '0;
        end
    end

    always_comb begin
        w_ain1 = '0;
        w_ain2 = '0;
        w_pwma = '0;
        w_ocup = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_st_nxt[i] == S_RUN || w_st_nxt[i] == S_RAMP_DN) begin
                w_ain1[i] = ~w_dir_nxt[i];
                w_ain2[i] = w_dir_nxt[i];
                w_pwma[i] = (r_cnt < w_duty_nxt[i]);
            end else if (w_st_nxt[i] == S_BRAKE) begin
                w_ain1[i] = 1'b1;
                w_ain2[i] = 1'b1;
                w_pwma[i] = 1'b1;
            end
            w_ocup[i] = (w_st_nxt[i] == S_RAMP_DN) || (w_st_nxt[i] == S_DEAD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= '0;
            r_tgt   <= '0;
            r_cnt   <= '0;
            r_sync  <= '0;
            r_pausa <= 1'b0;
            r_stby  <= 1'b0;
            r_timer <= '0;
            r_ain1  <= '0;
            r_ain2  <= '0;
            r_pwma  <= '0;
            r_ocup  <= '0;
            r_dir   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_st[i]   <= S_IDLE;
                r_duty[i] <= '0;
                r_div[i]  <= '0;
                r_dead[i] <= '0;
            end
        end else begin
            r_sel   <= sel;
            r_tgt   <= pwm_duty;
            r_cnt   <= r_cnt + D_ONE;
            r_sync  <= {r_sync[1:0], boton_pausa};
            r_pausa <= w_pausa_nxt;
            r_stby  <= ~w_pausa_nxt;
            r_timer <= w_timer_nxt;
            r_ain1  <= w_ain1;
            r_ain2  <= w_ain2;
            r_pwma  <= w_pwma;
            r_ocup  <= w_ocup;
            r_dir   <= w_dir_nxt;
            for (int i = 0; i < N_CH; i++) begin
                r_st[i]   <= w_st_nxt[i];
                r_duty[i] <= w_duty_nxt[i];
                r_div[i]  <= w_div_nxt[i];
                r_dead[i] <= w_dead_nxt[i];
            end
        end
    end

    assign AIN1    = r_ain1;
    assign AIN2    = r_ain2;
    assign PWMA    = r_pwma;
    assign ocupado = r_ocup;
    assign STBY    = r_stby;
    assign pausa   = r_pausa;
endmodule

// File: doc/controlador_motor_multi.md
CONTROLADOR_MOTOR_MULTI -- requirements
Module: controlador_motor_multi

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of H-bridge channels (1..4).
REQ-002 SHALL have parameter PWM_BITS, default 8: width of the PWM counter and of each duty word.
REQ-003 SHALL have parameter RAMP_DIV, default 1000: clk cycles per ±1 step of effective duty.
REQ-004 SHALL have parameter DEAD_CYCLES, default 50000: coast time (1 ms at 50 MHz) on direction reversal.
REQ-005 SHALL have parameter PAUSE_CYCLES, default 100000000: pause length (2 s at 50 MHz).
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 SHALL have port: clk  in  1  system clock (50 MHz).
REQ-008 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-009 SHALL have port: sel  in  2*N_CH  per-channel command; bits [2i+1:2i] belong to channel i.
  - 00 = coast, 01 = CW, 10 = CCW, 11 = brake.
REQ-010 SHALL have port: pwm_duty  in  N_CH*PWM_BITS  per-channel target duty; slice i at [PWM_BITS*i +: PWM_BITS].
REQ-011 SHALL have port: boton_pausa  in  1  asynchronous pause push-button, active-high.
REQ-012 SHALL have port: AIN1  out  N_CH  bridge input 1 per channel.
REQ-013 SHALL have port: AIN2  out  N_CH  bridge input 2 per channel.
REQ-014 SHALL have port: PWMA  out  N_CH  PWM per channel.
REQ-015 SHALL have port: STBY  out  1  driver enable, shared by all channels.
REQ-016 SHALL have port: pausa  out  1  high while the pause timer runs.
REQ-017 SHALL have port: ocupado  out  N_CH  high while a channel is in RAMP_DN or DEAD.

Function
REQ-018 SHALL use one free-running PWM_BITS counter shared by all channels, wrapping 2^PWM_BITS-1 -> 0.
REQ-019 SHALL drive PWMA[i] = (counter < duty_eff[i]).
  - duty_eff = 0 -> constant low.
  - duty_eff = max -> high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
REQ-020 SHALL synchronise boton_pausa through 2 flip-flops, then rising-edge detect it; a press acts 3 cycles after the input rises.
REQ-021 SHALL give each channel its own FSM with states IDLE, RUN, RAMP_DN, DEAD, BRAKE, and a registered current direction dir_i (CW/CCW).
REQ-022 SHALL take these FSM transitions:
  - IDLE -> RUN on sel 01/10; dir_i latched; duty_eff starts at 0.
  - IDLE/RUN -> BRAKE on sel 11.
  - RUN -> RAMP_DN on sel 00, or on a sel direction opposite to dir_i.
  - RAMP_DN -> DEAD when duty_eff reaches 0, if the target is the opposite direction.
  - RAMP_DN -> IDLE when duty_eff reaches 0, if sel = 00.
  - DEAD -> RUN after DEAD_CYCLES cycles; dir_i takes the new direction.
  - BRAKE -> IDLE on sel 00.
  - BRAKE -> DEAD on sel 01/10 (dead time always precedes drive after brake).
REQ-023 SHALL, in RUN, step duty_eff by ±1 every RAMP_DIV cycles toward the sampled pwm_duty slice, without overshoot.
  - A target change mid-ramp retargets at the next step.
REQ-024 SHALL, in RAMP_DN, step duty_eff by -1 every RAMP_DIV cycles regardless of pwm_duty.
REQ-025 SHALL drive the bridge outputs per state:
  - RUN/RAMP_DN with CW: AIN1=1, AIN2=0.
  - RUN/RAMP_DN with CCW: AIN1=0, AIN2=1.
  - IDLE/DEAD: AIN1=0, AIN2=0, PWMA=0.
  - BRAKE: AIN1=1, AIN2=1, PWMA=1.
REQ-026 SHALL never assert AIN1 and AIN2 driving opposite directions in consecutive cycles; every reversal passes through at least DEAD_CYCLES of coast.
REQ-027 SHALL, in RAMP_DN, treat sel reverting to the current dir_i as a return to RUN, with ramp-up from the present duty_eff.
REQ-028 SHALL, on a pause edge while not paused, load PAUSE_CYCLES and assert pausa.
  - STBY=0.
  - All channels forced to IDLE with duty_eff=0.
  - The FSMs hold in IDLE while pausa=1.
REQ-029 SHALL ignore pause edges while pausa=1 (the timer is not retriggered).
REQ-030 SHALL, when the pause count expires, deassert pausa and set STBY=1 in the same cycle.
  - Channels re-evaluate sel on the next cycle and ramp from 0.
REQ-031 SHALL register all outputs.
  - A sel change reaches AIN1/AIN2 two cycles later (input register + output register).
REQ-032 SHALL let pause take priority over any sel transition occurring in the same cycle.
REQ-033 SHALL size all counters to their parameter values; duty arithmetic SHALL saturate at 0 and 2^PWM_BITS-1.

Reset
REQ-034 SHALL, while rst=1, hold:
  - AIN1=0, AIN2=0, PWMA=0, STBY=0, pausa=0, ocupado=0.
  - PWM counter=0, duty_eff=0, all FSMs IDLE, pause timer=0, synchroniser flops=0.
REQ-035 SHALL set STBY=1 in the first cycle after rst falls; rst asserted mid-ramp, mid-dead-time or mid-pause SHALL abort immediately to the reset state.

Verification
(N_CH=2, PWM_BITS=4, RAMP_DIV=2, DEAD_CYCLES=8, PAUSE_CYCLES=100.)
REQ-036 SHALL check soft start: ch0 sel=01, duty=15 -> AIN1[0]=1 and AIN2[0]=0 two cycles later; duty_eff reaches 15 after 30 cycles; PWMA duty 15/16.
REQ-037 SHALL check reversal: ch0 running CW at duty 8, sel->10.
  - Ramp to 0 in 16 cycles.
  - 8 cycles with AIN1=AIN2=0.
  - Then AIN2=1 with ramp-up; ocupado[0]=1 throughout ramp-down and dead time.
REQ-038 SHALL check brake: ch1 sel=11 -> AIN1[1]=AIN2[1]=PWMA[1]=1; sel->01 gives 8 coast cycles before AIN1[1]=1.
REQ-039 SHALL check pause: 1-cycle pulse on boton_pausa.
  - pausa=1 and STBY=0 3 cycles later; all PWMA=0.
  - A second pulse during the pause is ignored.
  - STBY=1 after 100 cycles; channels ramp from 0.
REQ-040 SHALL check reset mid-operation: rst high during DEAD -> all outputs 0 next edge; STBY=1 one cycle after release.
REQ-041 SHALL check duty boundaries: duty 0 in RUN keeps PWMA low; duty 15 gives exactly one low cycle per 16.
